// File: rtl/f_stage_if.sv
// IM fetch bus plus the fetch-side bundle handed to the F/D register.
// master: fetch stage (drives addr and bundle); slave: IM and F/D register.
interface f_stage_if;
  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;
  logic [31:0] pc_F;
  logic [31:0] inst_F;
  logic [4:0]  ExcCode_F;
  logic        BD_F;

  modport master (
    output i_inst_addr,
    input  i_inst_rdata,
    output pc_F,
    output inst_F,
    output ExcCode_F,
    output BD_F
  );

  modport slave (
    input  i_inst_addr,
    output i_inst_rdata,
    input  pc_F,
    input  inst_F,
    input  ExcCode_F,
    input  BD_F
  );
endinterface

// File: rtl/f_stage.sv
// Fetch stage: PC register, next-PC select, AdEL detect, delay-slot mark.
// Ports: clk, reset, stall, req, eret_D, epc, branch_D, npc_take, npc_target, im (IM bus + F/D bundle).
module f_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter logic [31:0] IM_END     = 32'h0000_6ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        req,
  input  logic        eret_D,
  input  logic [31:0] epc,
  input  logic        branch_D,
  input  logic        npc_take,
  input  logic [31:0] npc_target,
  f_stage_if.master   im
);

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        adel;

  // One-hot selects encode the redirect priority.
  logic sel_req;
  logic sel_hold;
  logic sel_eret;
  logic sel_take;
  logic sel_seq;

  assign sel_req  = req;
  assign sel_hold = !req && stall;
  assign sel_eret = !req && !stall && eret_D;
  assign sel_take = !req && !stall && !eret_D && npc_take;
  assign sel_seq  = !req && !stall && !eret_D && !npc_take;

  always_comb begin
    pc_next = pc + 32'd4;
    unique case (1'b1)
      sel_req:  pc_next = HANDLER_PC;
      sel_hold: pc_next = pc;
      sel_eret: pc_next = epc;
      sel_take: pc_next = npc_target;
      sel_seq:  pc_next = pc + 32'd4;
      default:  pc_next = pc + 32'd4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) pc <= RESET_PC;
    else       pc <= pc_next;
  end

  assign adel = (pc[1:0] != 2'b00)
              | (pc < IM_BASE)
              | (pc > IM_END);

  assign im.i_inst_addr = pc;
  assign im.pc_F        = pc;

  // eret has no delay slot, so whatever follows it is squashed to a nop.
  always_comb begin
    im.inst_F    = im.i_inst_rdata;
    im.ExcCode_F = 5'd0;
    im.BD_F      = branch_D;
    if (eret_D) begin
      im.inst_F    = 32'd0;
      im.ExcCode_F = 5'd0;
      im.BD_F      = 1'b0;
    end else if (adel) begin
      im.inst_F    = 32'd0;
      im.ExcCode_F = 5'd4;
      im.BD_F      = branch_D;
    end
  end

endmodule
